// File: rtl/reg_encode.sv
// reg_encode: turns full 4-bit register addresses into (set_pa, instr) beats
// and tracks the decoder's play area so that set-pa is only issued on a change.
module reg_encode #(
  parameter int SPLIT_PA = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_addr,
  input  logic             in_force_pa,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_set_pa,
  output logic [1:0]       out_instr,
  output logic             out_pa_only,
  output logic [CNT_W-1:0] pa_switches,
  output logic [1:0]       cur_pa,
  output logic             pa_known
);

  localparam bit SPLIT = (SPLIT_PA != 0);

  typedef enum logic [1:0] {IDLE, PA_BEAT, OP_BEAT} state_t;

  state_t           state, state_nxt;
  logic [3:0]       addr_q;
  logic             need_q;
  logic [1:0]       cur_pa_q;
  logic             known_q;
  logic [CNT_W-1:0] cnt_q;

  logic             in_fire;
  logic             pa_update;
  logic             op_merge;
  logic [1:0]       eff_pa;
  logic             eff_known;
  logic             need_new;

  // Area-change test for a new request, made against the play area as it
  // will be after the current beat retires (a merged set-pa updates it).
  always_comb begin
    op_merge  = !SPLIT && need_q;
    eff_pa    = cur_pa_q;
    eff_known = known_q;
    if (state == OP_BEAT && op_merge) begin
      eff_pa    = addr_q[3:2];
      eff_known = 1'b1;
    end
    need_new = in_force_pa || !eff_known || (in_addr[3:2] != eff_pa);
  end

  // Next-state and beat fields derived from the current state and holding register.
  always_comb begin
    state_nxt   = state;
    out_valid   = 1'b0;
    in_ready    = 1'b0;
    out_set_pa  = '0;
    out_instr   = '0;
    out_pa_only = 1'b0;
    pa_update   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = (SPLIT && need_new) ? PA_BEAT : OP_BEAT;
      end
      PA_BEAT: begin
        out_valid   = 1'b1;
        out_set_pa  = {1'b1, addr_q[3:2]};
        out_pa_only = 1'b1;
        if (out_ready) begin
          pa_update = 1'b1;
          state_nxt = OP_BEAT;
        end
      end
      OP_BEAT: begin
        out_valid  = 1'b1;
        out_instr  = addr_q[1:0];
        out_set_pa = op_merge ? {1'b1, addr_q[3:2]} : {1'b0, cur_pa_q};
        in_ready   = out_ready;
        if (out_ready) begin
          pa_update = op_merge;
          if (in_valid)
            state_nxt = (SPLIT && need_new) ? PA_BEAT : OP_BEAT;
          else
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_fire = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Holding register plus tracked play area and saturating switch counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      need_q   <= 1'b0;
      cur_pa_q <= '0;
      known_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (in_fire) begin
        addr_q <= in_addr;
        need_q <= need_new;
      end
      if (pa_update) begin
        cur_pa_q <= addr_q[3:2];
        known_q  <= 1'b1;
        if (cnt_q != '1)
          cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign pa_switches = cnt_q;
  assign cur_pa      = cur_pa_q;
  assign pa_known    = known_q;

endmodule

// File: tb/tb_reg_encode.sv
// Directed bench for reg_encode: split-beat instance driven from a vector
// table plus hand-written stall/reset/saturation sequences, and a merged-beat
// instance for the single-beat set-pa form.
module tb_reg_encode;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // split instance signals
  logic       rst1, v1, f1, ordy1, ir1, ov1, po1, k1;
  logic [3:0] a1;
  logic [2:0] sp1;
  logic [1:0] ins1, cur1;
  logic [7:0] cnt1;

  // merged instance signals
  logic       rst0, v0, f0, ordy0, ir0, ov0, po0, k0;
  logic [3:0] a0;
  logic [2:0] sp0;
  logic [1:0] ins0, cur0;
  logic [7:0] cnt0;

  reg_encode #(.SPLIT_PA(1), .CNT_W(8)) dut (
    .clk(clk), .reset(rst1), .in_valid(v1), .in_ready(ir1), .in_addr(a1),
    .in_force_pa(f1), .out_valid(ov1), .out_ready(ordy1), .out_set_pa(sp1),
    .out_instr(ins1), .out_pa_only(po1), .pa_switches(cnt1), .cur_pa(cur1),
    .pa_known(k1));

  reg_encode #(.SPLIT_PA(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(rst0), .in_valid(v0), .in_ready(ir0), .in_addr(a0),
    .in_force_pa(f0), .out_valid(ov0), .out_ready(ordy0), .out_set_pa(sp0),
    .out_instr(ins0), .out_pa_only(po0), .pa_switches(cnt0), .cur_pa(cur0),
    .pa_known(k0));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [3:0] a;
    logic       r;
    logic [18:0] exp; // {out_valid, set_pa, instr, pa_only, in_ready, cnt, cur_pa, known}
  } vec_t;

  function automatic vec_t mk(logic v, logic [3:0] a, logic r, logic ov, logic [2:0] s,
                              logic [1:0] i, logic p, logic ir, logic [7:0] c,
                              logic [1:0] cur, logic k);
    vec_t t;
    t.v = v; t.a = a; t.r = r;
    t.exp = {ov, s, i, p, ir, c, cur, k};
    return t;
  endfunction

  function automatic logic [18:0] snap1();
    return {ov1, sp1, ins1, po1, ir1, cnt1, cur1, k1};
  endfunction

  vec_t tv[14];

  initial begin
    rst1 = 1; v1 = 0; f1 = 0; ordy1 = 1; a1 = '0;
    rst0 = 1; v0 = 0; f0 = 0; ordy0 = 1; a0 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst1 = 0; rst0 = 0;

    @(negedge clk);
    check("reset_state", {13'd0, snap1()}, {13'd0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b1, 8'd0, 2'd0, 1'b0});
    @(posedge clk); #1;

    // B (new area 2), stream 8..B in area 2, then alternate 1, D, 1
    tv[0]  = mk(1, 4'hB, 1, 0, 3'b000, 2'b00, 0, 1, 8'd0, 2'd0, 0);
    tv[1]  = mk(1, 4'h8, 1, 1, 3'b110, 2'b00, 1, 0, 8'd0, 2'd0, 0);
    tv[2]  = mk(1, 4'h8, 1, 1, 3'b010, 2'b11, 0, 1, 8'd1, 2'd2, 1);
    tv[3]  = mk(1, 4'h9, 1, 1, 3'b010, 2'b00, 0, 1, 8'd1, 2'd2, 1);
    tv[4]  = mk(1, 4'hA, 1, 1, 3'b010, 2'b01, 0, 1, 8'd1, 2'd2, 1);
    tv[5]  = mk(1, 4'hB, 1, 1, 3'b010, 2'b10, 0, 1, 8'd1, 2'd2, 1);
    tv[6]  = mk(1, 4'h1, 1, 1, 3'b010, 2'b11, 0, 1, 8'd1, 2'd2, 1);
    tv[7]  = mk(1, 4'hD, 1, 1, 3'b100, 2'b00, 1, 0, 8'd1, 2'd2, 1);
    tv[8]  = mk(1, 4'hD, 1, 1, 3'b000, 2'b01, 0, 1, 8'd2, 2'd0, 1);
    tv[9]  = mk(1, 4'h1, 1, 1, 3'b111, 2'b00, 1, 0, 8'd2, 2'd0, 1);
    tv[10] = mk(1, 4'h1, 1, 1, 3'b011, 2'b01, 0, 1, 8'd3, 2'd3, 1);
    tv[11] = mk(0, 4'h0, 1, 1, 3'b100, 2'b00, 1, 0, 8'd3, 2'd3, 1);
    tv[12] = mk(0, 4'h0, 1, 1, 3'b000, 2'b01, 0, 1, 8'd4, 2'd0, 1);
    tv[13] = mk(0, 4'h0, 1, 0, 3'b000, 2'b00, 0, 1, 8'd4, 2'd0, 1);

    for (int i = 0; i < 14; i++) begin
      v1 = tv[i].v; a1 = tv[i].a; ordy1 = tv[i].r;
      @(negedge clk);
      check($sformatf("vec%0d", i), {13'd0, snap1()}, {13'd0, tv[i].exp});
      @(posedge clk); #1;
    end

    // stall in PA_BEAT, then reset mid-sequence
    v1 = 1; a1 = 4'hE; ordy1 = 1;
    @(posedge clk); #1;
    a1 = 4'h5; ordy1 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d", i), {24'd0, ov1, sp1, ins1, po1, ir1},
            {24'd0, 1'b1, 3'b111, 2'b00, 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    rst1 = 1; v1 = 0; ordy1 = 1;
    @(posedge clk); #1;
    rst1 = 0;
    @(negedge clk);
    check("post_reset", {20'd0, ov1, k1, cnt1, cur1}, {20'd0, 1'b0, 1'b0, 8'd0, 2'd0});
    @(posedge clk); #1;
    v1 = 1; a1 = 4'h0;
    @(posedge clk); #1;
    v1 = 0;
    @(negedge clk);
    check("post_reset_pa", {27'd0, ov1, sp1, po1}, {27'd0, 1'b1, 3'b100, 1'b1});
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_op", {25'd0, ov1, sp1, ins1, po1}, {25'd0, 1'b1, 3'b000, 2'b00, 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_idle", {20'd0, ov1, k1, cnt1, cur1}, {20'd0, 1'b0, 1'b1, 8'd1, 2'd0});

    // merged set-pa form: 6 then 7
    @(posedge clk); #1;
    v0 = 1; a0 = 4'h6;
    @(posedge clk); #1;
    a0 = 4'h7;
    @(negedge clk);
    check("merged_beat1", {24'd0, ov0, sp0, ins0, po0, ir0}, {24'd0, 1'b1, 3'b101, 2'b10, 1'b0, 1'b1});
    @(posedge clk); #1;
    v0 = 0;
    @(negedge clk);
    check("merged_beat2", {24'd0, ov0, sp0, ins0, po0, ir0}, {24'd0, 1'b1, 3'b001, 2'b11, 1'b0, 1'b1});
    @(posedge clk); #1;
    @(negedge clk);
    check("merged_idle", {20'd0, ov0, k0, cnt0, cur0}, {20'd0, 1'b0, 1'b1, 8'd1, 2'd1});
    @(posedge clk); #1;

    // forced set-pa to the same area until the counter saturates
    rst1 = 1;
    @(posedge clk); #1;
    rst1 = 0;
    begin
      int sent = 0, pab = 0, opb = 0, bad = 0, cyc = 0;
      while (opb < 260 && cyc < 2000) begin
        v1 = (sent < 260); a1 = 4'h5; f1 = 1; ordy1 = 1;
        @(negedge clk);
        if (v1 && ir1) sent++;
        if (ov1 && po1) begin
          pab++;
          if (sp1 !== 3'b101) bad++;
        end
        if (ov1 && !po1) opb++;
        @(posedge clk); #1;
        cyc++;
      end
      v1 = 0; f1 = 0;
      check("force_pa_beats", pab, 260);
      check("force_op_beats", opb, 260);
      check("force_pa_fields", bad, 0);
      @(negedge clk);
      check("saturated_cnt", {24'd0, cnt1}, 32'd255);
      check("force_cur_pa", {29'd0, k1, cur1}, {29'd0, 1'b1, 2'd1});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
